vga_sync_gen: RTL and testbench

//  Free-running VGA timing generator; upstream of the background, sprite and text

---
 rtl/vga_sync_gen.sv | 123 ++++++++++++
 tb/tb_vga_sync_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing generator.
// A clock divider produces a one-clk pixel tick; horizontal and vertical
// counters advance on that tick. hsync, vsync, video_on and frame_start are
// registered from the next-state counts, so they change in the same clk as
// pixel_x/pixel_y and never glitch.
module vga_sync_gen #(
   parameter int TICK_DIV = 2,
   parameter int H_DISP   = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_DISP   = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start
);

   localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

   localparam logic [2:0]  DIV_MAX = 3'(TICK_DIV - 1);
   localparam logic [9:0]  H_MAX   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_MAX   = 10'(V_TOTAL - 1);

   // Region bounds are 11 bits wide so a sync end of exactly 1024 still compares correctly.
   localparam logic [10:0] H_VIS   = 11'(H_DISP);
   localparam logic [10:0] H_SS    = 11'(H_DISP + H_FP);
   localparam logic [10:0] H_SE    = 11'(H_DISP + H_FP + H_SYNC);
   localparam logic [10:0] V_VIS   = 11'(V_DISP);
   localparam logic [10:0] V_SS    = 11'(V_DISP + V_FP);
   localparam logic [10:0] V_SE    = 11'(V_DISP + V_FP + V_SYNC);

   localparam logic        SYNC_ON = (SYNC_POL != 0);

   logic [2:0] r_div;
   logic       r_p_tick;
   logic [9:0] r_x;
   logic [9:0] r_y;
   logic       r_video_on;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_frame_start;

   logic       w_div_last;
   logic       w_x_end;
   logic       w_y_end;
   logic       w_frame_end;
   logic [9:0] w_x_next;
   logic [9:0] w_y_next;
   logic       w_h_act;
   logic       w_v_act;
   logic       w_vis;

   // Next-state counts and the region decodes taken from them.
   always_comb begin
      w_div_last  = (r_div == DIV_MAX);
      w_x_end     = (r_x == H_MAX);
      w_y_end     = (r_y == V_MAX);
      w_frame_end = r_p_tick & w_x_end & w_y_end;
      w_x_next    = r_x;
      w_y_next    = r_y;
      if (r_p_tick) begin
         w_x_next = w_x_end ? 10'd0 : r_x + 10'd1;
         if (w_x_end) begin
            w_y_next = w_y_end ? 10'd0 : r_y + 10'd1;
         end
      end
      w_h_act = ({1'b0, w_x_next} >= H_SS) && ({1'b0, w_x_next} < H_SE);
      w_v_act = ({1'b0, w_y_next} >= V_SS) && ({1'b0, w_y_next} < V_SE);
      w_vis   = ({1'b0, w_x_next} < H_VIS) && ({1'b0, w_y_next} < V_VIS);
   end

   // Pixel tick divider: the tick is registered off the last divider state,
   // so the first tick appears TICK_DIV clks after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div    <= 3'd0;
         r_p_tick <= 1'b0;
      end else begin
         r_div    <= w_div_last ? 3'd0 : r_div + 3'd1;
         r_p_tick <= w_div_last;
      end
   end

   // Horizontal/vertical counters with syncs, video_on and frame_start aligned to them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x           <= 10'd0;
         r_y           <= 10'd0;
         r_video_on    <= 1'b1;
         r_hsync       <= ~SYNC_ON;
         r_vsync       <= ~SYNC_ON;
         r_frame_start <= 1'b0;
      end else begin
         r_x           <= w_x_next;
         r_y           <= w_y_next;
         r_video_on    <= w_vis;
         r_hsync       <= w_h_act ? SYNC_ON : ~SYNC_ON;
         r_vsync       <= w_v_act ? SYNC_ON : ~SYNC_ON;
         r_frame_start <= w_frame_end;
      end
   end

   assign p_tick      = r_p_tick;
   assign pixel_x     = r_x;
   assign pixel_y     = r_y;
   assign video_on    = r_video_on;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen.
// Three instances: default 640x480 timing, default horizontal timing with a
// short 12-line frame (keeps whole-frame runs short), and a tiny TICK_DIV=1 raster.
module tb_vga_sync_gen;

   logic clk;
   logic rst0, rst1, rst2;

   logic       tk0, vo0, hs0, vs0, fs0;
   logic [9:0] x0, y0;
   logic       tk1, vo1, hs1, vs1, fs1;
   logic [9:0] x1, y1;
   logic       tk2, vo2, hs2, vs2, fs2;
   logic [9:0] x2, y2;

   int         sel;
   logic       s_tk, s_vo, s_hs, s_vs, s_fs;
   logic [9:0] s_x, s_y;

   int n_checks = 0;
   int n_errors = 0;

   int m_xmax, m_ymax, m_hbad, m_vbad, m_vidbad, m_stepbad, m_tickbad;
   int m_fscnt, m_fsbad, m_fsgap, m_fsticks;
   int m_hstart_x, m_hrun, m_vstart_y, m_vrun, m_vidfall_x;

   vga_sync_gen u_dflt (
      .clk(clk), .reset_n(rst0), .p_tick(tk0), .pixel_x(x0), .pixel_y(y0),
      .video_on(vo0), .hsync(hs0), .vsync(vs0), .frame_start(fs0)
   );

   vga_sync_gen #(
      .TICK_DIV(2), .V_DISP(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) u_mid (
      .clk(clk), .reset_n(rst1), .p_tick(tk1), .pixel_x(x1), .pixel_y(y1),
      .video_on(vo1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
   );

   vga_sync_gen #(
      .TICK_DIV(1), .H_DISP(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) u_tiny (
      .clk(clk), .reset_n(rst2), .p_tick(tk2), .pixel_x(x2), .pixel_y(y2),
      .video_on(vo2), .hsync(hs2), .vsync(vs2), .frame_start(fs2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #950000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   always_comb begin
      s_tk = tk0; s_x = x0; s_y = y0; s_vo = vo0; s_hs = hs0; s_vs = vs0; s_fs = fs0;
      if (sel == 1) begin
         s_tk = tk1; s_x = x1; s_y = y1; s_vo = vo1; s_hs = hs1; s_vs = vs1; s_fs = fs1;
      end else if (sel == 2) begin
         s_tk = tk2; s_x = x2; s_y = y2; s_vo = vo2; s_hs = hs2; s_vs = vs2; s_fs = fs2;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Watch the selected instance for n clks, sampling on the falling edge.
   task automatic scan(input int n, input int tick,
                       input int h_total, input int h_disp, input int h_ss, input int h_se,
                       input int v_total, input int v_disp, input int v_ss, input int v_se);
      int px, py, pt, ph, pv, pvo;
      int ex, ey, since, had_tick, cyc, fs_cyc, tk_since_fs;
      int hst, hcnt, vst, vcnt, vf_done;
      logic h_exp, v_exp, vo_exp, fs_exp;
      m_xmax = 0; m_ymax = 0; m_hbad = 0; m_vbad = 0; m_vidbad = 0; m_stepbad = 0;
      m_tickbad = 0; m_fscnt = 0; m_fsbad = 0; m_fsgap = 0; m_fsticks = 0;
      m_hstart_x = -1; m_hrun = -1; m_vstart_y = -1; m_vrun = -1; m_vidfall_x = -1;
      @(negedge clk);
      px = int'(s_x); py = int'(s_y); pt = int'(s_tk); ph = int'(s_hs);
      pv = int'(s_vs); pvo = int'(s_vo);
      since = 0; had_tick = pt; cyc = 0; fs_cyc = 0; tk_since_fs = 0;
      hst = 0; hcnt = 0; vst = 0; vcnt = 0; vf_done = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (pt != 0) begin
            ex = (px == h_total - 1) ? 0 : px + 1;
            ey = (px == h_total - 1) ? ((py == v_total - 1) ? 0 : py + 1) : py;
         end else begin
            ex = px;
            ey = py;
         end
         if (int'(s_x) != ex || int'(s_y) != ey) m_stepbad++;
         if (int'(s_x) > m_xmax) m_xmax = int'(s_x);
         if (int'(s_y) > m_ymax) m_ymax = int'(s_y);
         since++;
         if (s_tk) begin
            if (had_tick != 0 && since != tick) m_tickbad++;
            had_tick = 1;
            since = 0;
            tk_since_fs++;
         end
         fs_exp = (pt != 0) && (px == h_total - 1) && (py == v_total - 1);
         if (s_fs != fs_exp) m_fsbad++;
         if (s_fs) begin
            m_fscnt++;
            if (m_fscnt >= 2) begin
               m_fsgap = cyc - fs_cyc;
               m_fsticks = tk_since_fs;
            end
            fs_cyc = cyc;
            tk_since_fs = 0;
         end
         h_exp = !(int'(s_x) >= h_ss && int'(s_x) < h_se);
         v_exp = !(int'(s_y) >= v_ss && int'(s_y) < v_se);
         vo_exp = (int'(s_x) < h_disp) && (int'(s_y) < v_disp);
         if (s_hs != h_exp) m_hbad++;
         if (s_vs != v_exp) m_vbad++;
         if (s_vo != vo_exp) m_vidbad++;
         if (hst == 0 && ph == 1 && !s_hs) begin
            hst = 1; hcnt = 0; m_hstart_x = int'(s_x);
         end
         if (hst == 1) begin
            if (!s_hs) hcnt++;
            else begin m_hrun = hcnt; hst = 2; end
         end
         if (vst == 0 && pv == 1 && !s_vs) begin
            vst = 1; vcnt = 0; m_vstart_y = int'(s_y);
         end
         if (vst == 1) begin
            if (!s_vs) vcnt++;
            else begin m_vrun = vcnt; vst = 2; end
         end
         if (vf_done == 0 && pvo == 1 && !s_vo && int'(s_y) < v_disp) begin
            m_vidfall_x = int'(s_x);
            vf_done = 1;
         end
         px = int'(s_x); py = int'(s_y); pt = int'(s_tk); ph = int'(s_hs);
         pv = int'(s_vs); pvo = int'(s_vo);
      end
   endtask

   initial begin
      int found;
      sel = 0;
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values, default instance
      check("rst_p_tick", int'(s_tk), 0);
      check("rst_x", int'(s_x), 0);
      check("rst_y", int'(s_y), 0);
      check("rst_video_on", int'(s_vo), 1);
      check("rst_hsync", int'(s_hs), 1);
      check("rst_vsync", int'(s_vs), 1);
      check("rst_frame_start", int'(s_fs), 0);

      // Release: first tick 2 clks later, then every 2 clks
      rst0 = 1'b1;
      @(negedge clk);
      check("e1_tick", int'(s_tk), 0);
      check("e1_fs", int'(s_fs), 0);
      @(negedge clk);
      check("e2_tick", int'(s_tk), 1);
      check("e2_x", int'(s_x), 0);
      @(negedge clk);
      check("e3_tick", int'(s_tk), 0);
      check("e3_x", int'(s_x), 1);
      check("e3_fs", int'(s_fs), 0);
      @(negedge clk);
      check("e4_tick", int'(s_tk), 1);

      // Two lines at default timing
      scan(3210, 2, 800, 640, 656, 752, 525, 480, 490, 492);
      check("dflt_xmax", m_xmax, 799);
      check("dflt_step", m_stepbad, 0);
      check("dflt_tick", m_tickbad, 0);
      check("dflt_hsync", m_hbad, 0);
      check("dflt_vsync", m_vbad, 0);
      check("dflt_video", m_vidbad, 0);
      check("dflt_hstart_x", m_hstart_x, 656);
      check("dflt_hrun_clks", m_hrun, 192);
      check("dflt_vidfall_x", m_vidfall_x, 640);
      check("dflt_fs_cnt", m_fscnt, 0);
      check("dflt_y_after_2_lines", m_ymax, 2);

      // Two full frames, 800x12 raster, TICK_DIV=2
      sel = 1;
      rst1 = 1'b1;
      scan(38800, 2, 800, 640, 656, 752, 12, 6, 8, 10);
      check("mid_xmax", m_xmax, 799);
      check("mid_ymax", m_ymax, 11);
      check("mid_step", m_stepbad, 0);
      check("mid_tick", m_tickbad, 0);
      check("mid_hsync", m_hbad, 0);
      check("mid_vsync", m_vbad, 0);
      check("mid_video", m_vidbad, 0);
      check("mid_fs_bad", m_fsbad, 0);
      check("mid_fs_cnt", m_fscnt, 2);
      check("mid_fs_gap_clks", m_fsgap, 19200);
      check("mid_fs_gap_ticks", m_fsticks, 9600);
      check("mid_vstart_y", m_vstart_y, 8);
      check("mid_vrun_clks", m_vrun, 3200);

      // Reset in the middle of both sync pulses
      found = 0;
      for (int i = 0; i < 20000 && found == 0; i++) begin
         @(negedge clk);
         if (int'(s_x) == 700 && int'(s_y) == 8) found = 1;
      end
      check("mid_reach_700_8", found, 1);
      check("pre_rst_hsync", int'(s_hs), 0);
      check("pre_rst_vsync", int'(s_vs), 0);
      rst1 = 1'b0;
      #1;
      check("async_hsync", int'(s_hs), 1);
      check("async_vsync", int'(s_vs), 1);
      check("async_x", int'(s_x), 0);
      check("async_y", int'(s_y), 0);
      check("async_tick", int'(s_tk), 0);
      check("async_video", int'(s_vo), 1);
      repeat (3) @(negedge clk);
      check("held_hsync", int'(s_hs), 1);
      check("held_x", int'(s_x), 0);
      rst1 = 1'b1;
      scan(1700, 2, 800, 640, 656, 752, 12, 6, 8, 10);
      check("rel_step", m_stepbad, 0);
      check("rel_hstart_x", m_hstart_x, 656);
      check("rel_hrun_clks", m_hrun, 192);
      check("rel_fs_cnt", m_fscnt, 0);
      check("rel_hsync", m_hbad, 0);

      // Tiny raster, TICK_DIV=1: 12-clk line, 84-clk frame
      sel = 2;
      rst2 = 1'b1;
      @(negedge clk);
      check("tiny_e1_tick", int'(s_tk), 1);
      check("tiny_e1_x", int'(s_x), 0);
      check("tiny_e1_fs", int'(s_fs), 0);
      @(negedge clk);
      check("tiny_e2_tick", int'(s_tk), 1);
      check("tiny_e2_x", int'(s_x), 1);
      scan(180, 1, 12, 8, 9, 11, 7, 4, 5, 6);
      check("tiny_xmax", m_xmax, 11);
      check("tiny_ymax", m_ymax, 6);
      check("tiny_step", m_stepbad, 0);
      check("tiny_tick", m_tickbad, 0);
      check("tiny_hsync", m_hbad, 0);
      check("tiny_vsync", m_vbad, 0);
      check("tiny_video", m_vidbad, 0);
      check("tiny_hstart_x", m_hstart_x, 9);
      check("tiny_hrun_clks", m_hrun, 2);
      check("tiny_vstart_y", m_vstart_y, 5);
      check("tiny_vrun_clks", m_vrun, 12);
      check("tiny_vidfall_x", m_vidfall_x, 8);
      check("tiny_fs_bad", m_fsbad, 0);
      check("tiny_fs_cnt", m_fscnt, 2);
      check("tiny_fs_gap_clks", m_fsgap, 84);
      check("tiny_fs_gap_ticks", m_fsticks, 84);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
